// File: rtl/bus_to_uart.sv
// bus_to_uart: bus slave that takes serial single-byte writes and resends each
// byte as a UART frame. After each frame it waits for an 8-bit acknowledge
// from the far end and retransmits on a bad or missing ack, up to a retry limit.
module bus_to_uart #(
  parameter logic [1:0] DEV_ID      = 2'b01,
  parameter logic [7:0] ACK_PATTERN = 8'b11001100,
  parameter logic [9:0] ACK_TIMEOUT = 10'd64,
  parameter logic [2:0] MAX_RETRY   = 3'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        slave_valid,
  input  logic        addr_in,
  input  logic        data_in,
  input  logic        uart_rx,
  output logic        slave_ready,
  output logic        uart_tx,
  output logic [11:0] last_addr,
  output logic [7:0]  last_data,
  output logic        ack_ok,
  output logic        ack_fail
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    TX_START,
    TX_DATA,
    TX_STOP,
    ACK_WAIT,
    ACK_RX
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  bc_q, bc_d;
  logic        skip_q, skip_d;
  logic [10:0] addr_sr_q, addr_sr_d;
  logic [6:0]  data_sr_q, data_sr_d;
  logic [11:0] last_addr_q, last_addr_d;
  logic [7:0]  last_data_q, last_data_d;
  logic        slave_ready_q, slave_ready_d;
  logic        uart_tx_q, uart_tx_d;
  logic        ack_ok_q, ack_ok_d;
  logic        ack_fail_q, ack_fail_d;
  logic [2:0]  retry_q, retry_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic        fail_attempt;

  // Next-state logic: bus capture, address decode, UART transmit and ack receive.
  always_comb begin
    state_d       = state_q;
    bc_d          = bc_q;
    skip_d        = skip_q;
    addr_sr_d     = addr_sr_q;
    data_sr_d     = data_sr_q;
    last_addr_d   = last_addr_q;
    last_data_d   = last_data_q;
    slave_ready_d = slave_ready_q;
    uart_tx_d     = uart_tx_q;
    ack_ok_d      = 1'b0;
    ack_fail_d    = 1'b0;
    retry_d       = retry_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    rx_sr_d       = rx_sr_q;
    fail_attempt  = 1'b0;

    // The bus reopens one cycle after the ack outcome pulse.
    if (ack_ok_q || ack_fail_q) begin
      slave_ready_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        bc_d   = 4'd0;
        skip_d = 1'b0;
        if (slave_valid && slave_ready_q) begin
          addr_sr_d = {addr_sr_q[9:0], addr_in};
          bc_d      = 4'd1;
          state_d   = CAPTURE;
        end
      end

      CAPTURE: begin
        if (skip_q) begin
          if (!slave_valid) begin
            state_d = IDLE;
          end
        end else if (slave_valid) begin
          addr_sr_d = {addr_sr_q[9:0], addr_in};
          if (bc_q >= 4'd6) begin
            data_sr_d = {data_sr_q[5:0], data_in};
          end
          bc_d = bc_q + 4'd1;
          if (bc_q == 4'd1 && {addr_sr_q[0], addr_in} != DEV_ID) begin
            skip_d = 1'b1;
          end
          if (bc_q == 4'd13) begin
            last_addr_d   = {addr_sr_q[10:0], addr_in};
            last_data_d   = {data_sr_q, data_in};
            slave_ready_d = 1'b0;
            retry_d       = 3'd0;
            bc_d          = 4'd0;
            state_d       = TX_START;
          end
        end
      end

      TX_START: begin
        if (tick) begin
          uart_tx_d = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = TX_DATA;
        end
      end

      TX_DATA: begin
        if (tick) begin
          uart_tx_d = last_data_q[3'd7 - bit_cnt_q];
          if (bit_cnt_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      TX_STOP: begin
        if (tick) begin
          uart_tx_d  = 1'b1;
          wait_cnt_d = 10'd0;
          state_d    = ACK_WAIT;
        end
      end

      ACK_WAIT: begin
        if (tick) begin
          if (!uart_rx) begin
            rx_cnt_d = 4'd0;
            state_d  = ACK_RX;
          end else if (wait_cnt_q == ACK_TIMEOUT - 10'd1) begin
            fail_attempt = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 10'd1;
          end
        end
      end

      ACK_RX: begin
        if (tick) begin
          if (rx_cnt_q != 4'd8) begin
            rx_sr_d  = {rx_sr_q[6:0], uart_rx};
            rx_cnt_d = rx_cnt_q + 4'd1;
          end else if (uart_rx && rx_sr_q == ACK_PATTERN) begin
            ack_ok_d = 1'b1;
            state_d  = IDLE;
          end else begin
            fail_attempt = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A failed attempt either resends the held byte or gives up.
    if (fail_attempt) begin
      if (retry_q < MAX_RETRY) begin
        retry_d = retry_q + 3'd1;
        state_d = TX_START;
      end else begin
        ack_fail_d = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  // State register with synchronous reset; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bc_q          <= 4'd0;
      skip_q        <= 1'b0;
      addr_sr_q     <= 11'd0;
      data_sr_q     <= 7'd0;
      last_addr_q   <= 12'd0;
      last_data_q   <= 8'd0;
      slave_ready_q <= 1'b1;
      uart_tx_q     <= 1'b1;
      ack_ok_q      <= 1'b0;
      ack_fail_q    <= 1'b0;
      retry_q       <= 3'd0;
      bit_cnt_q     <= 3'd0;
      wait_cnt_q    <= 10'd0;
      rx_cnt_q      <= 4'd0;
      rx_sr_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      bc_q          <= bc_d;
      skip_q        <= skip_d;
      addr_sr_q     <= addr_sr_d;
      data_sr_q     <= data_sr_d;
      last_addr_q   <= last_addr_d;
      last_data_q   <= last_data_d;
      slave_ready_q <= slave_ready_d;
      uart_tx_q     <= uart_tx_d;
      ack_ok_q      <= ack_ok_d;
      ack_fail_q    <= ack_fail_d;
      retry_q       <= retry_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_sr_q       <= rx_sr_d;
    end
  end

  assign slave_ready = slave_ready_q;
  assign uart_tx     = uart_tx_q;
  assign last_addr   = last_addr_q;
  assign last_data   = last_data_q;
  assign ack_ok      = ack_ok_q;
  assign ack_fail    = ack_fail_q;

endmodule

// File: tb/tb_bus_to_uart.sv
// Testbench for bus_to_uart: drives serial bus writes, decodes the UART frames
// like a real receiver, answers with acknowledge bytes and checks the outcome
// against a transaction-level model of what each write should produce.
module tb_bus_to_uart;

  localparam logic [1:0] DEV_ID      = 2'b01;
  localparam logic [7:0] ACK_PATTERN = 8'hCC;
  localparam int         ACK_TIMEOUT = 64;
  localparam int         MAX_RETRY   = 2;
  localparam int         TICK_DIV    = 4;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        slave_valid;
  logic        addr_in;
  logic        data_in;
  logic        uart_rx;
  logic        slave_ready;
  logic        uart_tx;
  logic [11:0] last_addr;
  logic [7:0]  last_data;
  logic        ack_ok;
  logic        ack_fail;

  int testsRun    = 0;
  int testsFailed = 0;
  int okCount     = 0;
  int failCount   = 0;
  int tickCnt     = 0;

  logic [11:0] modelAddr = 12'd0;
  logic [7:0]  modelData = 8'd0;

  bus_to_uart dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .slave_valid (slave_valid),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .uart_rx     (uart_rx),
    .slave_ready (slave_ready),
    .uart_tx     (uart_tx),
    .last_addr   (last_addr),
    .last_data   (last_data),
    .ack_ok      (ack_ok),
    .ack_fail    (ack_fail)
  );

  // Free-running bus clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud enable: one single-cycle pulse every TICK_DIV clocks.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick    = (tickCnt == TICK_DIV - 1);
      tickCnt = (tickCnt + 1) % TICK_DIV;
    end
  end

  // Count every cycle on which an outcome pulse is high.
  initial begin
    forever begin
      @(negedge clk);
      if (ack_ok === 1'b1) okCount++;
      if (ack_fail === 1'b1) failCount++;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Waits for the negedge of the next tick cycle.
  task automatic waitTickSample();
    do @(negedge clk); while (tick !== 1'b1);
  endtask

  // Waits for the next tick edge, returning just after it.
  task automatic waitTickEdge();
    waitTickSample();
    @(posedge clk);
    #1;
  endtask

  // Drives one 14-bit address / 8-bit data bus write, optionally stalling.
  task automatic applyStimulus(input logic [13:0] a, input logic [7:0] d, input int stallAt, input int stallLen);
    @(posedge clk);
    #1;
    for (int bc = 0; bc < 14; bc++) begin
      if (bc == stallAt && stallLen > 0) begin
        slave_valid = 1'b0;
        addr_in     = 1'($urandom);
        data_in     = 1'($urandom);
        repeat (stallLen) begin
          @(posedge clk);
          #1;
        end
      end
      slave_valid = 1'b1;
      addr_in     = a[13 - bc];
      if (bc >= 6) data_in = d[13 - bc];
      else data_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    slave_valid = 1'b0;
  endtask

  // UART receiver on uart_tx: finds a start bit, then samples nBits bits per tick.
  task automatic waitFrame(input int nBits, input int budget, output bit found,
                           output logic [7:0] b, output logic stopBit, output int ticksWaited);
    int cyc;
    found       = 1'b0;
    b           = 8'd0;
    stopBit     = 1'b0;
    ticksWaited = 0;
    cyc         = 0;
    while (!found && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (tick === 1'b1) begin
        ticksWaited++;
        if (uart_tx === 1'b0) found = 1'b1;
      end
    end
    if (found) begin
      for (int i = 0; i < nBits; i++) begin
        waitTickSample();
        if (i < 8) b = {b[6:0], uart_tx};
        else stopBit = uart_tx;
      end
    end
  endtask

  // Sends one ack frame on uart_rx, one bit per tick, line idles high after.
  task automatic driveRxByte(input logic [7:0] v, input bit goodStop);
    logic [9:0] bits;
    bits = {1'b0, v, goodStop};
    @(posedge clk);
    #1;
    uart_rx = bits[9];
    for (int i = 8; i >= 0; i--) begin
      waitTickEdge();
      uart_rx = bits[i];
    end
    waitTickEdge();
    uart_rx = 1'b1;
  endtask

  // One complete write: bus transfer, expected frames, ack replies and outcome.
  task automatic doTransaction(input string tag, input logic [13:0] a, input logic [7:0] d,
                               input int stallAt, input int stallLen, input int nBad,
                               input bit silent, input bit randBad, input logic [7:0] badVal);
    int okBefore, failBefore, expFrames, cyc, tw;
    bit match, expOk, found;
    logic [7:0] b, bad;
    logic sb;
    okBefore   = okCount;
    failBefore = failCount;
    applyStimulus(a, d, stallAt, stallLen);
    match = (a[13:12] == DEV_ID);
    if (match) begin
      modelAddr = a[11:0];
      modelData = d;
      checkOutput({tag, "_ready_low"}, 32'(slave_ready), 32'd0);
      expOk     = (nBad <= MAX_RETRY);
      expFrames = expOk ? nBad + 1 : MAX_RETRY + 1;
      for (int f = 0; f < expFrames; f++) begin
        waitFrame(9, (ACK_TIMEOUT + 20) * TICK_DIV, found, b, sb, tw);
        checkOutput($sformatf("%s_frame%0d_seen", tag, f), 32'(found), 32'd1);
        if (!found) break;
        checkOutput($sformatf("%s_frame%0d_byte", tag, f), 32'(b), 32'(d));
        checkOutput($sformatf("%s_frame%0d_stop", tag, f), 32'(sb), 32'd1);
        if (f > 0 && silent)
          checkOutput($sformatf("%s_frame%0d_gap_ok", tag, f),
                      32'(tw >= ACK_TIMEOUT && tw <= ACK_TIMEOUT + 2), 32'd1);
        if (f < nBad) begin
          if (!silent) begin
            if (randBad && $urandom_range(0, 3) == 0) begin
              driveRxByte(ACK_PATTERN, 1'b0);
            end else begin
              bad = randBad ? 8'($urandom) : badVal;
              if (bad == ACK_PATTERN) bad = bad ^ 8'h01;
              driveRxByte(bad, 1'b1);
            end
          end
        end else begin
          driveRxByte(ACK_PATTERN, 1'b1);
        end
      end
      cyc = 0;
      while (okCount == okBefore && failCount == failBefore && cyc < (ACK_TIMEOUT + 20) * TICK_DIV) begin
        @(negedge clk);
        cyc++;
      end
      repeat (3) @(negedge clk);
      checkOutput({tag, "_ok_pulses"}, 32'(okCount - okBefore), expOk ? 32'd1 : 32'd0);
      checkOutput({tag, "_fail_pulses"}, 32'(failCount - failBefore), expOk ? 32'd0 : 32'd1);
      checkOutput({tag, "_ready_after"}, 32'(slave_ready), 32'd1);
    end else begin
      waitFrame(9, 40 * TICK_DIV, found, b, sb, tw);
      checkOutput({tag, "_no_frame"}, 32'(found), 32'd0);
      checkOutput({tag, "_ready_high"}, 32'(slave_ready), 32'd1);
      checkOutput({tag, "_no_pulses"}, 32'((okCount - okBefore) + (failCount - failBefore)), 32'd0);
    end
    checkOutput({tag, "_last_addr"}, 32'(last_addr), 32'(modelAddr));
    checkOutput({tag, "_last_data"}, 32'(last_data), 32'(modelData));
  endtask

  // Main sequence: reset, directed plan cases, then randomized writes.
  initial begin
    bit found;
    logic [7:0] b;
    logic sb;
    int tw, okBefore, failBefore;
    logic [1:0] top;
    logic [13:0] a;

    reset       = 1'b1;
    slave_valid = 1'b0;
    addr_in     = 1'b0;
    data_in     = 1'b0;
    uart_rx     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("reset_ready", 32'(slave_ready), 32'd1);
    checkOutput("reset_ack_ok", 32'(ack_ok), 32'd0);
    checkOutput("reset_ack_fail", 32'(ack_fail), 32'd0);
    checkOutput("reset_last_addr", 32'(last_addr), 32'd0);
    checkOutput("reset_last_data", 32'(last_data), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    doTransaction("basic", 14'b01_000000000101, 8'hA5, -1, 0, 0, 1'b0, 1'b0, 8'h00);
    doTransaction("stall", 14'b01_000000000101, 8'hA5, 4, 3, 0, 1'b0, 1'b0, 8'h00);
    doTransaction("devmiss", 14'b10_111100001111, 8'h77, -1, 0, 0, 1'b0, 1'b0, 8'h00);
    doTransaction("badack", 14'b01_001000110100, 8'h3C, -1, 0, 1, 1'b0, 1'b0, 8'hCD);
    doTransaction("noack", 14'b01_110011001100, 8'h81, -1, 0, 3, 1'b1, 1'b0, 8'h00);

    okBefore   = okCount;
    failBefore = failCount;
    applyStimulus(14'b01_010101010101, 8'h5A, -1, 0);
    waitFrame(4, 100, found, b, sb, tw);
    checkOutput("rst_frame_started", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("rst_ready", 32'(slave_ready), 32'd1);
    checkOutput("rst_last_data", 32'(last_data), 32'd0);
    modelAddr = 12'd0;
    modelData = 8'd0;
    waitFrame(9, 40 * TICK_DIV, found, b, sb, tw);
    checkOutput("rst_no_frame", 32'(found), 32'd0);
    checkOutput("rst_no_pulses", 32'((okCount - okBefore) + (failCount - failBefore)), 32'd0);
    doTransaction("after_rst", 14'b01_100000000001, 8'hE7, -1, 0, 0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do top = 2'($urandom); while (top == DEV_ID);
      end else begin
        top = DEV_ID;
      end
      a = {top, 12'($urandom)};
      doTransaction($sformatf("rand%0d", i), a, 8'($urandom), $urandom_range(0, 13),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
